// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a length/payload/checksum frame, writes
// little-endian 32-bit words into imem and holds the core in reset until a good image is in.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded,
   output logic [2:0]        dbgState
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LEN0  = 3'd1,
      LEN1  = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      DONE  = 3'd5,
      ERROR = 3'd6
   } stateT;

   stateT       state;
   stateT       nextState;

   logic [7:0]  lenLo;
   logic [16:0] numWords;
   logic [16:0] lenFull;
   logic [23:0] byteBuf;
   logic [1:0]  byteCnt;
   logic [7:0]  xorAcc;

   logic        accept;
   logic        startLoad;
   logic        wordComplete;
   logic        lastWord;
   logic        csumGood;

   // Handshake: a byte moves only on a cycle where in_valid and in_ready are both high;
   // in_ready depends on state alone, so a stalled byte stays put until consumed.
   always_comb begin
      in_ready = 1'b0;
      case (state)
         LEN0, LEN1, DATA, CSUM: in_ready = 1'b1;
         default:                in_ready = 1'b0;
      endcase
   end

   assign accept       = in_valid & in_ready;
   assign startLoad    = start & ((state == IDLE) | (state == DONE) | (state == ERROR));
   assign lenFull      = {1'b0, in_data, lenLo};
   assign wordComplete = accept & (state == DATA) & (byteCnt == 2'd3);
   assign lastWord     = ((17'(words_loaded) + 17'd1) == numWords);
   assign csumGood     = (in_data == xorAcc);
   assign dbgState     = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (startLoad) nextState = LEN0;
         end
         LEN0: begin
            if (accept) nextState = LEN1;
         end
         LEN1: begin
            if (accept) begin
               if (lenFull > 17'(DEPTH))  nextState = ERROR;
               else if (lenFull == 17'd0) nextState = CSUM;
               else                       nextState = DATA;
            end
         end
         DATA: begin
            if (wordComplete && lastWord) nextState = CSUM;
         end
         CSUM: begin
            if (accept) nextState = csumGood ? DONE : ERROR;
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath and registered outputs; the imem write lands the cycle after a word's 4th byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lenLo        <= 8'd0;
         numWords     <= 17'd0;
         byteBuf      <= 24'd0;
         byteCnt      <= 2'd0;
         xorAcc       <= 8'd0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 32'd0;
         words_loaded <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         core_hold    <= 1'b1;
      end else begin
         mem_we <= 1'b0;

         if (startLoad) begin
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            byteCnt      <= 2'd0;
            xorAcc       <= 8'd0;
            numWords     <= 17'd0;
            core_hold    <= 1'b1;
         end

         if (accept && (state == LEN0)) begin
            lenLo <= in_data;
         end

         if (accept && (state == LEN1)) begin
            numWords <= lenFull;
            if (lenFull > 17'(DEPTH)) error <= 1'b1;
         end

         if (accept && (state == DATA)) begin
            byteBuf <= {in_data, byteBuf[23:8]};
            byteCnt <= byteCnt + 2'd1;
            xorAcc  <= xorAcc ^ in_data;
         end

         if (wordComplete) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= {in_data, byteBuf};
            words_loaded <= words_loaded + 1'b1;
         end

         if (accept && (state == CSUM)) begin
            if (csumGood) begin
               done      <= 1'b1;
               core_hold <= 1'b0;
            end else begin
               error     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are driven byte by byte, expected imem writes
// are queued by the driver and checked by an independent write monitor.
module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int EW     = ADDR_W + 64;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;
   logic [2:0]        dbgState;

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;
   int gapCycles   = 0;

   // Each entry: {word address, word data, cycle in which mem_we must be seen}
   logic [EW-1:0] exp_q[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_hold    (core_hold),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .dbgState     (dbgState)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkStatus(input string tag, input logic expDone, input logic expErr,
                              input logic expHold, input int expWords);
      check({tag, "_done"},  done,         expDone);
      check({tag, "_error"}, error,        expErr);
      check({tag, "_hold"},  core_hold,    expHold);
      check({tag, "_words"}, words_loaded, 64'(expWords));
      check({tag, "_ready"}, in_ready,     1'b0);
   endtask

   // Write monitor
   always @(negedge clk) begin
      if (!reset && mem_we) begin
         if (exp_q.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL unexpected_write: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("wr_addr",  mem_addr,     e[EW-1 -: ADDR_W]);
            check("wr_data",  mem_wdata,    e[63:32]);
            check("wr_cycle", 64'(cyc),     64'(e[31:0]));
            check("wr_words", words_loaded, 64'(e[EW-1 -: ADDR_W]) + 64'd1);
         end
      end
   end

   // ---------------- driver tasks (called at negedge) ----------------
   task automatic sendByte(input logic [7:0] b, input bit expWrite,
                           input logic [ADDR_W-1:0] addr, input logic [31:0] w);
      int t;
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 64) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         nCompared++;
         nMismatched++;
         $display("FAIL accept_timeout: in_ready 0 want 1 for byte %0h", b);
         in_valid = 1'b0;
         return;
      end
      if (expWrite) exp_q.push_back({addr, w, 32'(cyc + 1)});
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gapCycles) @(negedge clk);
   endtask

   task automatic sendWord(input logic [ADDR_W-1:0] addr, input logic [31:0] w);
      sendByte(w[7:0],   1'b0, addr, w);
      sendByte(w[15:8],  1'b0, addr, w);
      sendByte(w[23:16], 1'b0, addr, w);
      sendByte(w[31:24], 1'b1, addr, w);
   endtask

   task automatic sendLen(input logic [15:0] n);
      sendByte(n[7:0],  1'b0, '0, 32'd0);
      sendByte(n[15:8], 1'b0, '0, 32'd0);
   endtask

   task automatic pulseStart(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_start_hold"},  core_hold,    1'b1);
      check({tag, "_start_done"},  done,         1'b0);
      check({tag, "_start_err"},   error,        1'b0);
      check({tag, "_start_words"}, words_loaded, 64'd0);
      check({tag, "_start_ready"}, in_ready,     1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] w;
      logic [7:0]  cs;

      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_ready", in_ready,     1'b0);
      check("rst_we",    mem_we,       1'b0);
      check("rst_addr",  mem_addr,     '0);
      check("rst_wdata", mem_wdata,    32'd0);
      check("rst_hold",  core_hold,    1'b1);
      check("rst_done",  done,         1'b0);
      check("rst_error", error,        1'b0);
      check("rst_words", words_loaded, 64'd0);

      // Bytes offered while idle must be ignored
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      check("idle_ignore_words", words_loaded, 64'd0);

      // 1: single word, good checksum
      pulseStart("t1");
      sendLen(16'd1);
      sendWord('0, 32'h00500513);
      sendByte(8'h46, 1'b0, '0, 32'd0);
      checkStatus("t1", 1'b1, 1'b0, 1'b0, 1);

      // 2: restart from DONE, three words with a gap after every byte
      gapCycles = 1;
      pulseStart("t2");
      sendLen(16'd3);
      sendWord(10'd0, 32'h11223344);
      sendWord(10'd1, 32'hA5A50F0F);
      sendWord(10'd2, 32'hDEADBEEF);
      sendByte(8'h66, 1'b0, '0, 32'd0);
      checkStatus("t2", 1'b1, 1'b0, 1'b0, 3);
      gapCycles = 0;

      // 3: bad checksum, word still written
      pulseStart("t3");
      sendLen(16'd1);
      sendWord('0, 32'h00500513);
      sendByte(8'hFF, 1'b0, '0, 32'd0);
      checkStatus("t3", 1'b0, 1'b1, 1'b1, 1);

      // 4a: empty image, checksum 00
      pulseStart("t4a");
      sendLen(16'd0);
      sendByte(8'h00, 1'b0, '0, 32'd0);
      checkStatus("t4a", 1'b1, 1'b0, 1'b0, 0);

      // 4b: empty image, checksum 01
      pulseStart("t4b");
      sendLen(16'd0);
      sendByte(8'h01, 1'b0, '0, 32'd0);
      checkStatus("t4b", 1'b0, 1'b1, 1'b1, 0);

      // 5: N = DEPTH+1 rejected right after LEN_HI
      pulseStart("t5");
      sendLen(16'(DEPTH + 1));
      checkStatus("t5", 1'b0, 1'b1, 1'b1, 0);

      // 6a: asynchronous reset in the middle of DATA
      pulseStart("t6a");
      sendLen(16'd2);
      sendWord(10'd0, 32'h01234567);
      sendByte(8'h89, 1'b0, '0, 32'd0);
      #1 reset = 1'b1;
      #1;
      check("t6a_ready", in_ready,     1'b0);
      check("t6a_we",    mem_we,       1'b0);
      check("t6a_addr",  mem_addr,     '0);
      check("t6a_wdata", mem_wdata,    32'd0);
      check("t6a_hold",  core_hold,    1'b1);
      check("t6a_done",  done,         1'b0);
      check("t6a_error", error,        1'b0);
      check("t6a_words", words_loaded, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 6b: start pulse during DATA is ignored
      pulseStart("t6b");
      sendLen(16'd2);
      sendByte(8'h0D, 1'b0, '0, 32'd0);
      start = 1'b1;
      sendByte(8'hF0, 1'b0, '0, 32'd0);
      start = 1'b0;
      sendByte(8'hFE, 1'b0, '0, 32'd0);
      sendByte(8'hCA, 1'b1, 10'd0, 32'hCAFEF00D);
      sendWord(10'd1, 32'h0BADC0DE);
      sendByte(8'h71, 1'b0, '0, 32'd0);
      checkStatus("t6b", 1'b1, 1'b0, 1'b0, 2);

      // Boundary: N == DEPTH fills imem up to the last address
      pulseStart("tfull");
      sendLen(16'(DEPTH));
      cs = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
         w  = 32'(i) * 32'h9E3779B1 + 32'h13572468;
         cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
         sendWord(ADDR_W'(i), w);
      end
      sendByte(cs, 1'b0, '0, 32'd0);
      checkStatus("tfull", 1'b1, 1'b0, 1'b0, DEPTH);

      repeat (3) @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
